// File: rtl/pulser_pkg.sv
// Shared types and defaults for the periodic channel pulse sequencer.
package pulser_pkg;

    typedef enum logic [1:0] {
        PULSE_ALL    = 2'b00,
        PULSE_ROLL   = 2'b01,
        PULSE_MASKED = 2'b10
    } pulse_mode_e;

    localparam int DEF_PERIOD_W    = 32;
    localparam int DEF_NUMCHANNELS = 64;
    localparam int DEF_WIDTH_W     = 8;
    localparam int DEF_BURST_W     = 16;

    // The unused encoding 2'b11 falls back to all-channel mode.
    function automatic pulse_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return PULSE_ROLL;
            2'b10:   return PULSE_MASKED;
            default: return PULSE_ALL;
        endcase
    endfunction

endpackage

// File: rtl/next_channel_finder.sv
// Circular priority search: first set mask bit at or above start_index, wrapping.
// Purely combinational; NUMCHANNELS need not be a power of two.
module next_channel_finder #(
    parameter  int NUMCHANNELS = 64,
    localparam int CH_W        = $clog2(NUMCHANNELS)
) (
    input  logic [NUMCHANNELS-1:0] mask,
    input  logic [CH_W-1:0]        start_index,
    output logic                   found,
    output logic [CH_W-1:0]        index
);

    int pos;

    // Scan from the far end so the nearest hit is written last and wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = 0;
        for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
            pos = int'(start_index) + i;
            if (pos >= NUMCHANNELS) begin
                pos = pos - NUMCHANNELS;
            end
            if (mask[pos]) begin
                found = 1'b1;
                index = CH_W'(pos);
            end
        end
    end

endmodule

// File: rtl/channel_pulse_sequencer.sv
// Periodic all/rolling/masked-rolling pulse generator, registered outputs; the fire edge drives the pulse.
// Optional burst limit compiled in with PULSER_BURST_EN.
module channel_pulse_sequencer
    import pulser_pkg::*;
#(
    parameter  int PERIOD_W    = DEF_PERIOD_W,
    parameter  int NUMCHANNELS = DEF_NUMCHANNELS,
    parameter  int WIDTH_W     = DEF_WIDTH_W,
    parameter  int BURST_W     = DEF_BURST_W,
    localparam int CH_W        = $clog2(NUMCHANNELS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [PERIOD_W-1:0]    pulse_cycles,
    input  logic [WIDTH_W-1:0]     pulse_width,
    input  logic [NUMCHANNELS-1:0] channel_mask,
    input  logic [BURST_W-1:0]     burst_count,
    input  logic                   start,
    output logic [NUMCHANNELS-1:0] periodic_pulse,
    output logic                   pulse_active,
    output logic [CH_W-1:0]        current_channel,
    output logic                   burst_done
);

    logic [PERIOD_W-1:0]    period_cnt;
    logic [WIDTH_W-1:0]     width_cnt;
    logic [CH_W-1:0]        pointer;
    logic [NUMCHANNELS-1:0] pattern;
    logic [CH_W-1:0]        fire_ch;
    logic [CH_W-1:0]        next_ptr;
    logic [CH_W-1:0]        target;
    logic [WIDTH_W-1:0]     width_load;
    logic                   found;
    logic                   pattern_ok;
    logic                   period_hit;
    logic                   burst_block;
    logic                   fire;
    logic                   clear;
    pulse_mode_e            mode_e;

    assign mode_e     = decode_mode(mode);
    assign clear      = !enable || start;
    assign period_hit = (period_cnt >= pulse_cycles);
    assign width_load = (pulse_width == '0) ? '0 : pulse_width - 1'b1;
    assign next_ptr   = (fire_ch == CH_W'(NUMCHANNELS - 1)) ? '0 : fire_ch + 1'b1;

    next_channel_finder #(.NUMCHANNELS(NUMCHANNELS)) u_finder (
        .mask        (channel_mask),
        .start_index (pointer),
        .found       (found),
        .index       (target)
    );

    always_comb begin
        pattern    = '0;
        fire_ch    = pointer;
        pattern_ok = 1'b1;
        case (mode_e)
            PULSE_ROLL: begin
                pattern[pointer] = 1'b1;
            end
            PULSE_MASKED: begin
                pattern[target] = 1'b1;
                fire_ch         = target;
                pattern_ok      = found;
            end
            default: pattern = '1;
        endcase
    end

    // An empty mask suppresses the fire entirely, so it is neither emitted nor counted.
    assign fire = period_hit && pattern_ok && !burst_block;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt      <= '0;
            width_cnt       <= '0;
            pointer         <= '0;
            periodic_pulse  <= '0;
            current_channel <= '0;
        end else if (clear) begin
            period_cnt     <= '0;
            width_cnt      <= '0;
            pointer        <= '0;
            periodic_pulse <= '0;
        end else begin
            period_cnt <= period_hit ? '0 : period_cnt + 1'b1;
            if (fire) begin
                periodic_pulse <= pattern;
                width_cnt      <= width_load;
                if (mode_e != PULSE_ALL) begin
                    pointer         <= next_ptr;
                    current_channel <= fire_ch;
                end
            end else if (width_cnt != '0) begin
                width_cnt <= width_cnt - 1'b1;
            end else begin
                periodic_pulse <= '0;
            end
        end
    end

    assign pulse_active = |periodic_pulse;

`ifdef PULSER_BURST_EN
    logic [BURST_W-1:0] burst_cnt;
    logic               burst_last;

    // Once done, fires stay blocked even if burst_count is later raised.
    assign burst_block = burst_done || ((burst_count != '0) && (burst_cnt >= burst_count));
    assign burst_last  = (burst_count != '0) &&
                         (({1'b0, burst_cnt} + 1'b1) >= {1'b0, burst_count});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt  <= '0;
            burst_done <= 1'b0;
        end else if (clear) begin
            burst_cnt  <= '0;
            burst_done <= 1'b0;
        end else if (period_hit && pattern_ok) begin
            if (burst_block) begin
                burst_done <= 1'b1;
            end else begin
                burst_cnt <= burst_cnt + 1'b1;
                if (burst_last) begin
                    burst_done <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_burst;

    assign unused_burst = ^burst_count;
    assign burst_block  = 1'b0;
    assign burst_done   = 1'b0;
`endif

endmodule

// File: tb/tb_channel_pulse_sequencer.sv
// Directed scoreboard bench for channel_pulse_sequencer with 8 channels.
module tb_channel_pulse_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] pulse_cycles;
    logic [3:0] pulse_width;
    logic [7:0] channel_mask;
    logic [3:0] burst_count;
    logic       start;
    logic [7:0] periodic_pulse;
    logic       pulse_active;
    logic [2:0] current_channel;
    logic       burst_done;

    channel_pulse_sequencer #(
        .PERIOD_W    (8),
        .NUMCHANNELS (8),
        .WIDTH_W     (4),
        .BURST_W     (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mode            (mode),
        .pulse_cycles    (pulse_cycles),
        .pulse_width     (pulse_width),
        .channel_mask    (channel_mask),
        .burst_count     (burst_count),
        .start           (start),
        .periodic_pulse  (periodic_pulse),
        .pulse_active    (pulse_active),
        .current_channel (current_channel),
        .burst_done      (burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pulse;
        int         ch;
        logic       bd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] mask_pulse[9] = '{8'h00, 8'h01, 8'h00, 8'h20, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
    int         mask_ch[9]    = '{-1, 0, 0, 5, 5, 7, 7, 0, 0};
    logic [7:0] retrig_pulse[12] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02,
                                     8'h02, 8'h02, 8'h04, 8'h04, 8'h04, 8'h08};
    int         retrig_ch[12]    = '{-1, -1, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares the state left by the previous rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("periodic_pulse", 32'(periodic_pulse), 32'(e.pulse));
            check("pulse_active", 32'(pulse_active), 32'(|e.pulse));
            check("burst_done", 32'(burst_done), 32'(e.bd));
            if (e.ch >= 0) begin
                check("current_channel", 32'(current_channel), 32'(e.ch));
            end
        end
    end

    task automatic step(input logic [7:0] p, input int ch, input logic bd);
        exp_t e;
        e.pulse = p;
        e.ch    = ch;
        e.bd    = bd;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_seq();
        enable = 1'b0;
        step(8'h00, -1, 1'b0);
        enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        mode         = 2'b00;
        pulse_cycles = 8'd3;
        pulse_width  = 4'd1;
        channel_mask = 8'h00;
        burst_count  = 4'd0;
        start        = 1'b0;
        #12;
        check("reset_pulse", 32'(periodic_pulse), 32'h0);
        check("reset_active", 32'(pulse_active), 32'h0);
        check("reset_channel", 32'(current_channel), 32'h0);
        check("reset_burst_done", 32'(burst_done), 32'h0);
        @(negedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;

        // All mode, period 4, width 1: first fire on the 4th enabled edge.
        for (int i = 1; i <= 9; i++) begin
            step((i % 4 == 0) ? 8'hFF : 8'h00, 0, 1'b0);
        end
        clear_seq();

        // Rolling with pulse_cycles=0: one channel per clock with wrap.
        mode         = 2'b01;
        pulse_cycles = 8'd0;
        for (int i = 0; i <= 8; i++) begin
            step(8'(1 << (i % 8)), i % 8, 1'b0);
        end
        clear_seq();

        // Masked rolling over mask 1010_0001, then an empty mask.
        mode         = 2'b10;
        pulse_cycles = 8'd1;
        channel_mask = 8'hA1;
        for (int i = 0; i < 9; i++) begin
            step(mask_pulse[i], mask_ch[i], 1'b0);
        end
        channel_mask = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step(8'h00, 0, 1'b0);
        end
        clear_seq();

        // Width longer than period: back-to-back retriggered pulses.
        mode         = 2'b01;
        pulse_cycles = 8'd2;
        pulse_width  = 4'd5;
        for (int i = 0; i < 12; i++) begin
            step(retrig_pulse[i], retrig_ch[i], 1'b0);
        end
        clear_seq();

        // Mode 11 acts as all; shrinking pulse_cycles below the count fires at once.
        mode         = 2'b11;
        pulse_width  = 4'd1;
        pulse_cycles = 8'd5;
        step(8'h00, -1, 1'b0);
        step(8'h00, -1, 1'b0);
        step(8'h00, -1, 1'b0);
        pulse_cycles = 8'd1;
        step(8'hFF, -1, 1'b0);
        step(8'h00, -1, 1'b0);
        step(8'hFF, -1, 1'b0);
        clear_seq();

        // Burst of 3 pulses, then start re-arms it.
        mode         = 2'b00;
        pulse_cycles = 8'd1;
        burst_count  = 4'd3;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 10; i++) begin
                logic f;
                logic d;
                f = (i % 2 == 0);
                d = 1'b0;
`ifdef PULSER_BURST_EN
                f = f && (i <= 6);
                d = (i >= 6);
`endif
                step(f ? 8'hFF : 8'h00, -1, d);
            end
            if (r == 0) begin
                start = 1'b1;
                step(8'h00, -1, 1'b0);
                start = 1'b0;
            end
        end
        burst_count = 4'd0;
        clear_seq();

        // Async reset mid-pulse, then restart from channel 0 with a full period.
        mode         = 2'b01;
        pulse_cycles = 8'd3;
        pulse_width  = 4'd3;
        step(8'h00, -1, 1'b0);
        step(8'h00, -1, 1'b0);
        step(8'h00, -1, 1'b0);
        step(8'h01, 0, 1'b0);
        reset = 1'b1;
        #1;
        check("async_reset_pulse", 32'(periodic_pulse), 32'h0);
        check("async_reset_active", 32'(pulse_active), 32'h0);
        step(8'h00, 0, 1'b0);
        reset = 1'b0;
        step(8'h00, 0, 1'b0);
        step(8'h00, 0, 1'b0);
        step(8'h00, 0, 1'b0);
        step(8'h01, 0, 1'b0);
        step(8'h01, 0, 1'b0);

        // Enable dropped mid-pulse clears on the next edge and resets the pointer.
        enable = 1'b0;
        step(8'h00, 0, 1'b0);
        enable = 1'b1;
        step(8'h00, 0, 1'b0);
        step(8'h00, 0, 1'b0);
        step(8'h00, 0, 1'b0);
        step(8'h01, 0, 1'b0);
        step(8'h01, 0, 1'b0);
        step(8'h01, 0, 1'b0);
        step(8'h00, 0, 1'b0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_pulse_sequencer.md
# channel_pulse_sequencer

Parametrised successor to the periodic reset/trigger pulser. Generates periodic pulses on NUMCHANNELS outputs in three modes: all-channel, rolling, and masked-rolling (skips masked-off channels). Pulse width is programmable. An optional burst limit stops after a programmed number of pulses. Sits in the digital core next to the channel config registers and drives per-channel periodic reset and periodic trigger.

## Interface
- PERIOD_W, 32, width of period counter / pulse_cycles
- NUMCHANNELS, 64, number of output channels (>= 2)
- WIDTH_W, 8, width of pulse_width
- BURST_W, 16, width of burst_count / burst counter
- Derived: CH_W = $clog2(NUMCHANNELS)

Ports:
- clk  in  1  master clock
- reset  in  1  asynchronous digital reset, active high
- enable  in  1  high runs the sequencer; low synchronously clears all state
- mode  in  2  00 all, 01 rolling, 10 masked-rolling, 11 treated as 00
- pulse_cycles  in  PERIOD_W  period is pulse_cycles+1 clocks
- pulse_width  in  WIDTH_W  pulse high time in clocks; 0 treated as 1
- channel_mask  in  NUMCHANNELS  1 = channel eligible (masked-rolling only)
- burst_count  in  BURST_W  pulses per burst; 0 = continuous
- start  in  1  single-cycle; restarts period counter, pointer and burst
- periodic_pulse  out  NUMCHANNELS  pulse outputs
- pulse_active  out  1  OR of periodic_pulse
- current_channel  out  CH_W  channel of most recent rolling pulse
- burst_done  out  1  sticky, burst limit reached

## Operation
- Reset: all outputs 0; period_cnt, width_cnt, pointer and burst_cnt are 0.
- enable low, or start high: period_cnt, width_cnt, pointer, burst_cnt, periodic_pulse and burst_done all go to 0 at the next edge. start takes priority over counting.
- Period: on each enabled edge, if period_cnt >= pulse_cycles then fire and set period_cnt to 0; otherwise increment. The >= compare makes a shrunk pulse_cycles fire on the next edge.
- Fire in all mode: periodic_pulse becomes all ones.
- Fire in rolling mode: periodic_pulse becomes one-hot at the pointer. current_channel takes the pointer value. The pointer then advances and wraps from NUMCHANNELS-1 to 0.
- Fire in masked-rolling mode:
  - Target is the first set mask bit at or above the pointer, searching circularly.
  - periodic_pulse becomes one-hot at the target; current_channel takes the target; the pointer becomes target+1 (wrapping).
  - If the mask is all zero, no pulse is emitted and the fire is not counted toward the burst.
- Width:
  - On fire, width_cnt loads max(pulse_width,1)-1.
  - Each later edge decrements width_cnt; when it is 0 and there is no fire, periodic_pulse clears.
  - A fire during an active pulse replaces the pattern and reloads width_cnt (retrigger). pulse_width > period therefore gives back-to-back or continuous pulses.
- Mode or mask change mid-operation takes effect at the next fire; the pointer is kept.

## Timing
- Output is registered.
- pulse_cycles = N: the first fire happens at enabled edge N+1 (counted from the first enabled edge after clear). Output goes high after that edge for W clocks. After that, fires repeat every N+1 clocks.
- pulse_cycles = 0: fires on every edge. In rolling mode each channel is high for 1 clock, in sequence.
- burst_done rises on the same edge as the final counted fire. That final pulse still completes its width.

## Configuration
- PULSER_BURST_EN defined:
  - burst_cnt increments on each counted fire.
  - When burst_count != 0 and burst_cnt reaches burst_count, no further fires occur and burst_done is set.
  - burst_done holds until start, enable low, or reset.
  - Changing burst_count to a value <= burst_cnt stops at the next fire.
- PULSER_BURST_EN undefined: burst_count is ignored, burst_done is tied to 0, there is no burst counter, and start still clears state.

## Structure
- Shared package pulser_pkg holds:
  - a mode enum (PULSE_ALL, PULSE_ROLL, PULSE_MASKED) with 2'b11 decoding as PULSE_ALL
  - default parameter constants
- Sub-module next_channel_finder (combinational circular priority search):
  - inputs: mask, start index
  - outputs: found, index
  - parametrised by NUMCHANNELS

## Test plan
- All mode, pulse_cycles=3, pulse_width=1 -> periodic_pulse all ones for 1 clk every 4 clks; first pulse after 4th enabled edge.
- Rolling, NUMCHANNELS=4, pulse_cycles=0 -> one-hot 0001,0010,0100,1000,0001 on consecutive clocks; current_channel 0,1,2,3,0.
- Masked-rolling, mask=0b1010_0001 (8 ch), pulse_cycles=1 -> channels 0,5,7,0; mask=0 -> no pulses and pulse_active stays 0.
- pulse_width=5, pulse_cycles=2 (retrigger) -> pulse_active continuously high; rolling channel switches every 3 clks.
- PULSER_BURST_EN, burst_count=3, pulse_cycles=1 -> exactly 3 pulses, then burst_done=1; start pulse -> burst_done=0 and 3 more pulses.
- reset asserted mid-pulse, and enable dropped mid-pulse -> outputs 0 (async, and next edge respectively); restart begins at channel 0 with a full period.
